// File: rtl/usrt_tx_front.sv
// USRT transmit front end: baud tick generator, one-byte holding register and frame builder.
// Optional overrun flag (o_Overrun) is built when USRT_TX_OVERRUN_EN is defined.
module usrt_tx_front #(
    parameter int BAUD_W = 14,
    parameter int DATA_W = 8
) (
    input  logic                i_Pclk,
    input  logic                i_Reset,
    input  logic                i_Enable,
    input  logic [DATA_W-1:0]   i_Data,
    input  logic [BAUD_W-1:0]   i_Baud,
    input  logic [1:0]          i_Parity,
    input  logic                i_Done,
`ifdef USRT_TX_OVERRUN_EN
    output logic                o_Overrun,
`endif
    output logic                o_Bclk,
    output logic [DATA_W-1:0]   o_Data,
    output logic [DATA_W+2:0]   o_Frame,
    output logic                o_Busy,
    output logic                o_Ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PENDING
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   cnt_q, cnt_d;
    logic [BAUD_W-1:0]   period_m1;
    logic                bclk_q, bclk_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W+2:0]   frame_q, frame_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                parity_bit;
`ifdef USRT_TX_OVERRUN_EN
    logic                overrun_q, overrun_d;
`endif

    // A divisor of 0 behaves as 1; ">=" lets a shrinking divisor force an immediate wrap.
    assign period_m1 = (i_Baud == '0) ? '0 : i_Baud - 1'b1;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q + 1'b1;
        bclk_d = 1'b0;
        if (cnt_q >= period_m1) begin
            cnt_d  = '0;
            bclk_d = 1'b1;
        end
    end

    always_comb begin
        case (i_Parity)
            2'd1:    parity_bit = ^data_q;
            2'd2:    parity_bit = ~(^data_q);
            default: parity_bit = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        frame_d = frame_q;
        busy_d  = busy_q;
        ready_d = ready_q;
`ifdef USRT_TX_OVERRUN_EN
        overrun_d = overrun_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_Enable) begin
                    data_d  = i_Data;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
`ifdef USRT_TX_OVERRUN_EN
                    overrun_d = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                frame_d = {1'b1, parity_bit, data_q, 1'b0};
                ready_d = 1'b1;
                state_d = ST_PENDING;
`ifdef USRT_TX_OVERRUN_EN
                if (i_Enable) overrun_d = 1'b1;
`endif
            end
            ST_PENDING: begin
                // Done wins over a simultaneous write; the write is dropped.
                if (i_Done) begin
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
`ifdef USRT_TX_OVERRUN_EN
                if (i_Enable) overrun_d = 1'b1;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_Pclk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bclk_q  <= 1'b0;
            data_q  <= '0;
            frame_q <= '1;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
`ifdef USRT_TX_OVERRUN_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bclk_q  <= bclk_d;
            data_q  <= data_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
`ifdef USRT_TX_OVERRUN_EN
            overrun_q <= overrun_d;
`endif
        end
    end

    assign o_Bclk  = bclk_q;
    assign o_Data  = data_q;
    assign o_Frame = frame_q;
    assign o_Busy  = busy_q;
    assign o_Ready = ready_q;
`ifdef USRT_TX_OVERRUN_EN
    assign o_Overrun = overrun_q;
`endif

endmodule

// File: tb/tb_usrt_tx_front.sv
// Scoreboard bench for usrt_tx_front: stimulus pushes expected frames, a monitor checks them on o_Ready.
module tb_usrt_tx_front;

    logic        clk;
    logic        rst_n;
    logic        i_Enable;
    logic [7:0]  i_Data;
    logic [13:0] i_Baud;
    logic [1:0]  i_Parity;
    logic        i_Done;
    logic        o_Bclk;
    logic [7:0]  o_Data;
    logic [10:0] o_Frame;
    logic        o_Busy;
    logic        o_Ready;
`ifdef USRT_TX_OVERRUN_EN
    logic        o_Overrun;
`endif

    usrt_tx_front #(.BAUD_W(14), .DATA_W(8)) dut (
        .i_Pclk   (clk),
        .i_Reset  (rst_n),
        .i_Enable (i_Enable),
        .i_Data   (i_Data),
        .i_Baud   (i_Baud),
        .i_Parity (i_Parity),
        .i_Done   (i_Done),
`ifdef USRT_TX_OVERRUN_EN
        .o_Overrun(o_Overrun),
`endif
        .o_Bclk   (o_Bclk),
        .o_Data   (o_Data),
        .o_Frame  (o_Frame),
        .o_Busy   (o_Busy),
        .o_Ready  (o_Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  parity;
        logic [10:0] frame;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic ready_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising o_Ready presents a frame that must match the oldest expectation.
    always @(negedge clk) begin
        if (o_Ready && !ready_prev) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame: got frame %0h with no expectation queued", o_Frame);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame", {21'd0, o_Frame}, {21'd0, e.frame});
                check("held_data", {24'd0, o_Data}, {24'd0, e.data});
            end
        end
        ready_prev = o_Ready;
    end

    task automatic write_byte(input logic [7:0] d, input logic [1:0] par, input logic [10:0] frame);
        i_Enable = 1'b1;
        i_Data   = d;
        i_Parity = par;
        sb.push_back('{data: d, frame: frame});
        @(negedge clk);
        i_Enable = 1'b0;
        check("busy_after_T", {31'd0, o_Busy}, 32'd1);
        check("ready_after_T", {31'd0, o_Ready}, 32'd0);
        @(negedge clk);
        check("ready_after_T1", {31'd0, o_Ready}, 32'd1);
    endtask

    task automatic done_pulse();
        i_Done = 1'b1;
        @(negedge clk);
        i_Done = 1'b0;
        check("busy_after_done", {31'd0, o_Busy}, 32'd0);
        check("ready_after_done", {31'd0, o_Ready}, 32'd0);
    endtask

    vec_t vecs[6];
    logic [14:0] bpat;
    logic [5:0]  bpat6;

    initial begin
        vecs[0] = '{data: 8'h35, parity: 2'd1, frame: 11'h46A};
        vecs[1] = '{data: 8'h35, parity: 2'd2, frame: 11'h66A};
        vecs[2] = '{data: 8'h07, parity: 2'd1, frame: 11'h60E};
        vecs[3] = '{data: 8'h07, parity: 2'd2, frame: 11'h40E};
        vecs[4] = '{data: 8'h07, parity: 2'd0, frame: 11'h60E};
        vecs[5] = '{data: 8'h07, parity: 2'd3, frame: 11'h60E};

        rst_n    = 1'b0;
        i_Enable = 1'b0;
        i_Data   = 8'h00;
        i_Baud   = 14'd5;
        i_Parity = 2'd0;
        i_Done   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bclk", {31'd0, o_Bclk}, 32'd0);
        check("rst_data", {24'd0, o_Data}, 32'd0);
        check("rst_frame", {21'd0, o_Frame}, 32'h7FF);
        check("rst_busy", {31'd0, o_Busy}, 32'd0);
        check("rst_ready", {31'd0, o_Ready}, 32'd0);
        rst_n = 1'b1;

        // Divisor 5: tick after edges 5, 10, 15.
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            bpat[k] = o_Bclk;
        end
        check("baud5_pattern", {17'd0, bpat}, {17'd0, 15'b100001000010000});

        i_Baud = 14'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bpat6[k] = o_Bclk;
        end
        check("baud0_every_cycle", {26'd0, bpat6}, {26'd0, 6'b111111});

        // Count climbs to 6 under divisor 10, then shrinking to 3 forces a wrap.
        i_Baud = 14'd10;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bpat6[k] = o_Bclk;
        end
        check("baud10_no_tick", {26'd0, bpat6}, 32'd0);
        i_Baud = 14'd3;
        @(negedge clk);
        check("baud_shrink_tick", {31'd0, o_Bclk}, 32'd1);
        i_Baud = 14'd7;

        for (int v = 0; v < 6; v++) begin
            write_byte(vecs[v].data, vecs[v].parity, vecs[v].frame);
            repeat (2) @(negedge clk);
            check("hold_ready", {31'd0, o_Ready}, 32'd1);
            done_pulse();
            @(negedge clk);
        end

        // Writes and parity changes while pending must not disturb the held frame.
        write_byte(8'h35, 2'd1, 11'h46A);
        i_Enable = 1'b1;
        i_Data   = 8'hAA;
        i_Parity = 2'd2;
        @(negedge clk);
        i_Enable = 1'b0;
        repeat (3) @(negedge clk);
        check("pend_data_kept", {24'd0, o_Data}, 32'h35);
        check("pend_frame_kept", {21'd0, o_Frame}, 32'h46A);
        check("pend_busy", {31'd0, o_Busy}, 32'd1);
`ifdef USRT_TX_OVERRUN_EN
        check("overrun_set", {31'd0, o_Overrun}, 32'd1);
`endif
        done_pulse();
        @(negedge clk);

        // Done with a simultaneous write: back to IDLE, write dropped.
        write_byte(8'h07, 2'd1, 11'h60E);
        i_Enable = 1'b1;
        i_Done   = 1'b1;
        i_Data   = 8'hC3;
        @(negedge clk);
        i_Enable = 1'b0;
        i_Done   = 1'b0;
        check("en_done_busy", {31'd0, o_Busy}, 32'd0);
        check("en_done_ready", {31'd0, o_Ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("en_done_busy_later", {31'd0, o_Busy}, 32'd0);
        check("en_done_data", {24'd0, o_Data}, 32'h07);

        // Done in IDLE is ignored.
        i_Done = 1'b1;
        @(negedge clk);
        i_Done = 1'b0;
        @(negedge clk);
        check("idle_done_busy", {31'd0, o_Busy}, 32'd0);
        check("idle_done_ready", {31'd0, o_Ready}, 32'd0);
        check("idle_done_frame", {21'd0, o_Frame}, 32'h60E);

`ifdef USRT_TX_OVERRUN_EN
        write_byte(8'h5A, 2'd0, 11'h6B4);
        check("overrun_cleared", {31'd0, o_Overrun}, 32'd0);
        done_pulse();
        @(negedge clk);
`endif

        // Asynchronous reset in the middle of a pending frame, with o_Bclk high.
        i_Baud = 14'd1;
        write_byte(8'h35, 2'd2, 11'h66A);
        @(negedge clk);
        check("pre_rst_bclk", {31'd0, o_Bclk}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, o_Busy}, 32'd0);
        check("arst_ready", {31'd0, o_Ready}, 32'd0);
        check("arst_bclk", {31'd0, o_Bclk}, 32'd0);
        check("arst_frame", {21'd0, o_Frame}, 32'h7FF);
        check("arst_data", {24'd0, o_Data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
